// File: rtl/oam_dma.sv
// oam_dma: halts the CPU and copies a 256-byte page to a fixed register address.
// Optional I_abort port is enabled by defining OAM_DMA_ABORT_EN.
module oam_dma #(
    parameter int          P_addr_bits = 16,
    parameter int          P_data_bits = 8,
    parameter logic [15:0] P_dest_addr = 16'h2004
) (
    input  logic                   I_clock,
    input  logic                   I_reset_n,
    input  logic                   I_tick,
    input  logic                   I_start,
    input  logic [7:0]             I_page,
    input  logic                   I_phase,
`ifdef OAM_DMA_ABORT_EN
    input  logic                   I_abort,
`endif
    input  logic [P_data_bits-1:0] I_data,
    output logic [P_addr_bits-1:0] O_addr,
    output logic                   O_wren,
    output logic [P_data_bits-1:0] O_data,
    output logic                   O_halt,
    output logic                   O_busy,
    output logic                   O_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_e;

    localparam logic [P_addr_bits-1:0] DEST = P_addr_bits'(P_dest_addr);

    state_e                 state_q, state_d;
    logic [7:0]             index_q, index_d;
    logic [7:0]             page_q, page_d;
    logic [P_data_bits-1:0] cap_q, cap_d;
    logic                   pend_q, pend_d;
    logic [P_addr_bits-1:0] addr_q, addr_d;
    logic                   abort;

`ifdef OAM_DMA_ABORT_EN
    assign abort = I_abort;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        page_d  = page_q;
        pend_d  = 1'b0;
        // read data arrives one clock after the ticked READ edge
        cap_d   = pend_q ? I_data : cap_q;
        addr_d  = addr_q;
        O_wren  = 1'b0;
        O_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (I_tick && I_start) begin
                    state_d = S_HALT;
                    page_d  = I_page;
                    index_d = 8'd0;
                end
            end
            S_HALT: begin
                if (I_tick) begin
                    if (abort)        state_d = S_IDLE;
                    else if (I_phase) state_d = S_ALIGN;
                    else              state_d = S_READ;
                end
            end
            S_ALIGN: begin
                if (I_tick) state_d = abort ? S_IDLE : S_READ;
            end
            S_READ: begin
                addr_d = P_addr_bits'({page_q, index_q});
                if (I_tick) begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WRITE;
                        pend_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                addr_d = DEST;
                O_wren = I_tick;
                if (I_tick) begin
                    if (index_q == 8'hFF || abort) begin
                        state_d = S_IDLE;
                        O_done  = !abort;
                    end else begin
                        state_d = S_READ;
                        index_d = index_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clock or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            page_q  <= '0;
            cap_q   <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            page_q  <= page_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
        end
    end

    // on the first WRITE clock the capture is still in flight: forward it
    assign O_data = pend_q ? I_data : cap_q;
    assign O_addr = addr_d;
    assign O_busy = (state_q != S_IDLE);
    assign O_halt = O_busy;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a synchronous one-clock-latency memory model.
// Abort scenario is built when OAM_DMA_ABORT_EN is defined.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  page = 8'h00;
    logic        phase = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic [15:0] addr;
    logic        wren;
    logic [7:0]  wdata;
    logic        halt;
    logic        busy;
    logic        done;
`ifdef OAM_DMA_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_addr [0:4095];
    logic [7:0]  wr_data [0:4095];
    int wr_cnt = 0;
    int busy_ticks = 0;
    int done_cnt = 0;
    int bad07 = 0;
    int xt = 0;
    int first_rd = 0;
    bit stall = 1'b0;
    int tcnt = 0;

    oam_dma dut (
        .I_clock  (clk),
        .I_reset_n(rst_n),
        .I_tick   (tick),
        .I_start  (start),
        .I_page   (page),
        .I_phase  (phase),
`ifdef OAM_DMA_ABORT_EN
        .I_abort  (abort),
`endif
        .I_data   (rdata),
        .O_addr   (addr),
        .O_wren   (wren),
        .O_data   (wdata),
        .O_halt   (halt),
        .O_busy   (busy),
        .O_done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

    always @(posedge clk) begin
        #1;
        tcnt = tcnt + 1;
        tick = stall ? (tcnt % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!busy) begin
            xt = 0;
        end else if (tick) begin
            xt = xt + 1;
            busy_ticks = busy_ticks + 1;
            if (addr == 16'h0300 && !wren) first_rd = xt;
        end
        if (wren) begin
            wr_addr[wr_cnt % 4096] = addr;
            wr_data[wr_cnt % 4096] = wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (tick && done) done_cnt = done_cnt + 1;
        if (busy && addr[15:8] == 8'h07) bad07 = bad07 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] pg, input logic ph);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #2;
        page  = pg;
        phase = ph;
        start = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (busy) ok = 1'b1;
        end
        start = 1'b0;
        page  = 8'hFF;
        check("start_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk);
            #2;
            if (!busy) ok = 1'b1;
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_data(input string tag, input int base, input int n);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            e = 8'(i) ^ 8'h5A;
            if (wr_addr[(base + i) % 4096] != 16'h2004) bad++;
            if (wr_data[(base + i) % 4096] != e) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, {16'd0, addr}, 32'd0);
        check({tag, "_wren"}, {31'd0, wren}, 32'd0);
        check({tag, "_data"}, {24'd0, wdata}, 32'd0);
        check({tag, "_halt"}, {31'd0, halt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int wb, bb, db, b7, w;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hC3;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
            mem[16'h0700 + i] = 8'hEE;
        end
        mem[16'h2004] = 8'h00;

        repeat (3) @(posedge clk);
        #3;
        check_reset_outs("reset");
        rst_n = 1'b1;

        // basic even-aligned transfer
        wb = wr_cnt; bb = busy_ticks; db = done_cnt;
        start_xfer(8'h03, 1'b0);
        wait_idle(1000);
        check("basic_writes", wr_cnt - wb, 256);
        check_data("basic_data", wb, 256);
        check("basic_busy", busy_ticks - bb, 513);
        check("basic_done", done_cnt - db, 1);
        check("basic_first_rd", first_rd, 2);

        // odd alignment inserts one ALIGN tick
        wb = wr_cnt; bb = busy_ticks; db = done_cnt;
        start_xfer(8'h03, 1'b1);
        wait_idle(1000);
        check("odd_writes", wr_cnt - wb, 256);
        check_data("odd_data", wb, 256);
        check("odd_busy", busy_ticks - bb, 514);
        check("odd_first_rd", first_rd, 3);
        check("odd_done", done_cnt - db, 1);
        phase = 1'b0;

        // one tick in three
        stall = 1'b1;
        wb = wr_cnt; bb = busy_ticks; db = done_cnt;
        start_xfer(8'h03, 1'b0);
        wait_idle(3000);
        check("stall_writes", wr_cnt - wb, 256);
        check_data("stall_data", wb, 256);
        check("stall_busy", busy_ticks - bb, 513);
        check("stall_done", done_cnt - db, 1);
        stall = 1'b0;

        // start while busy is ignored
        wb = wr_cnt; db = done_cnt; b7 = bad07;
        start_xfer(8'h03, 1'b0);
        for (int i = 0; i < 1000 && (wr_cnt - wb) < 100; i++) @(posedge clk);
        #2;
        page = 8'h07;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle(1000);
        check("busy_start_writes", wr_cnt - wb, 256);
        check_data("busy_start_data", wb, 256);
        check("busy_start_no07", bad07 - b7, 0);
        check("busy_start_done", done_cnt - db, 1);

        // asynchronous reset mid-transfer
        wb = wr_cnt; db = done_cnt;
        start_xfer(8'h03, 1'b0);
        for (int i = 0; i < 1000 && (wr_cnt - wb) < 40; i++) begin
            @(posedge clk);
            #3;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        w = wr_cnt;
        check("midreset_count", w - wb, 40);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        check("midreset_no_wr", wr_cnt - w, 0);
        check("midreset_no_done", done_cnt - db, 0);
        check("midreset_idle", {31'd0, busy}, 32'd0);

`ifdef OAM_DMA_ABORT_EN
        // abort during the WRITE of index 10
        wb = wr_cnt; db = done_cnt;
        start_xfer(8'h03, 1'b0);
        for (int i = 0; i < 1000 && !abort; i++) begin
            @(negedge clk);
            if (wren && wdata == (8'd10 ^ 8'h5A)) abort = 1'b1;
        end
        @(posedge clk);
        #2;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #2;
        check("abort_writes", wr_cnt - wb, 11);
        check_data("abort_data", wb, 11);
        check("abort_done", done_cnt - db, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
